// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM state type, default widths
// and the write-protection boundary.
package lsu_pkg;

  localparam int LSU_ADDR_W = 8;
  localparam int LSU_DATA_W = 8;

  // Addresses strictly below this are write-protected when LSU_PROTECT_EN is defined.
  localparam logic [7:0] LSU_PROT_LIMIT = 8'h20;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACCESS     = 2'd1,
    WRITE_BACK = 2'd2,
    RESP       = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response channel between the execute stage (master) and the load/store unit (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = lsu_pkg::LSU_ADDR_W,
  parameter int DATA_W = lsu_pkg::LSU_DATA_W
);

  // Both channels: a transfer happens on a rising edge where valid && ready; the sender
  // holds valid and its payload stable until that edge, ready may change freely.
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage driving the data memory: LOAD/STORE in one access cycle, SWAP as read then write.
// Optional write protection of low addresses is enabled with the LSU_PROTECT_EN macro.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output state_t            dbg_state
);

  state_t            state;
  state_t            state_next;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              fault_q;
  logic              prot_hit;
  logic              accept;

  assign accept = bus.req_valid && (state == IDLE);

`ifdef LSU_PROTECT_EN
  assign prot_hit = ((op_q == OP_STORE) || (op_q == OP_SWAP)) &&
                    (addr_q < ADDR_W'(LSU_PROT_LIMIT));
`else
  assign prot_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (accept) state_next = (bus.req_op == OP_NOP) ? RESP : ACCESS;
      ACCESS:     state_next = (op_q == OP_SWAP) ? WRITE_BACK : RESP;
      WRITE_BACK: state_next = RESP;
      RESP:       if (bus.rsp_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Address/data only move for real accesses so the memory bus holds its last value across NOPs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.req_op;
        rdata_q <= '0;
        fault_q <= 1'b0;
        if (bus.req_op != OP_NOP) begin
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
        end
      end
      if (state == ACCESS) begin
        fault_q <= prot_hit;
        if ((op_q == OP_LOAD) || (op_q == OP_SWAP)) rdata_q <= mem_read_data;
      end
    end
  end

  // Enables are gated by rst so a reset during WRITE_BACK drops the pending write.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!rst) begin
      case (state)
        ACCESS: begin
          mem_read  = (op_q == OP_LOAD) || (op_q == OP_SWAP);
          mem_write = (op_q == OP_STORE) && !prot_hit;
        end
        WRITE_BACK: mem_write = !prot_hit;
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_fault  = fault_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural data memory and a response scoreboard.
module tb_mem_access_unit;
  import lsu_pkg::*;

`ifdef LSU_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_read_data;
  state_t     dbg_state;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and shadow ----------------
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] = mem_write_data;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int rd_count = 0;
  logic [7:0] wr_addr = 8'h00;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_write) begin
      wr_count++;
      wr_addr = mem_address;
    end
    if (mem_read) rd_count++;
    if (mem_read || mem_write) check("rd_wr_excl", {31'd0, mem_read & mem_write}, 0);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e[7:0]);
        check("rsp_fault", bus.rsp_fault, e[8]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_req(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                          input int hold, input bit rand_rdy);
    logic       fault;
    logic [7:0] rdata;
    int         lat;
    int         exp_lat;
    bit         done;
    fault = PROT && ((op == OP_STORE) || (op == OP_SWAP)) && (addr < 8'h20);
    rdata = 8'h00;
    case (op)
      OP_LOAD:  rdata = ref_mem[addr];
      OP_STORE: if (!fault) ref_mem[addr] = wdata;
      OP_SWAP: begin
        rdata = ref_mem[addr];
        if (!fault) ref_mem[addr] = wdata;
      end
      default: ;
    endcase
    exp_lat = (op == OP_NOP) ? 1 : (op == OP_SWAP) ? 3 : 2;
    exp_q.push_back({fault, rdata});

    @(negedge clk);
    bus.rsp_ready = (hold == 0);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'($urandom_range(0, 255));
    check("acc_mem_read", {31'd0, mem_read}, (op == OP_LOAD) || (op == OP_SWAP));
    if (op != OP_NOP) check("acc_mem_address", mem_address, addr);
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);

    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", {31'd0, bus.rsp_valid}, 1);
      check("hold_rsp_rdata", bus.rsp_rdata, rdata);
      check("hold_req_ready", {31'd0, bus.req_ready}, 0);
      check("hold_mem_idle", {30'd0, mem_read, mem_write}, 0);
    end

    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      bus.rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      if (bus.req_ready) done = 1'b1;
    end
    bus.rsp_ready = 1'b1;
    check("complete", {31'd0, done}, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int r0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    mem[8'h20] = 8'h0A;
    mem[8'h21] = 8'h05;
    mem[8'h22] = 8'h02;
    mem[8'h23] = 8'h03;
    for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, bus.req_ready}, 1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_fault", {31'd0, bus.rsp_fault}, 0);
    check("rst_mem_en", {30'd0, mem_read, mem_write}, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_write_data", mem_write_data, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    // LOAD of preloaded location
    send_req(OP_LOAD, 8'h20, 8'h00, 0, 1'b0);

    // STORE then LOAD back
    w0 = wr_count;
    send_req(OP_STORE, 8'h40, 8'h55, 0, 1'b0);
    check("store_wr_pulses", wr_count - w0, 1);
    check("store_wr_addr", wr_addr, 8'h40);
    send_req(OP_LOAD, 8'h40, 8'h00, 0, 1'b0);

    // SWAP: one read then one write, then LOAD sees new data
    w0 = wr_count;
    r0 = rd_count;
    send_req(OP_SWAP, 8'h21, 8'h99, 0, 1'b0);
    check("swap_wr_pulses", wr_count - w0, 1);
    check("swap_rd_pulses", rd_count - r0, 1);
    check("swap_wr_addr", wr_addr, 8'h21);
    send_req(OP_LOAD, 8'h21, 8'h00, 0, 1'b0);

    // Response back-pressure for four cycles
    w0 = wr_count;
    r0 = rd_count;
    send_req(OP_LOAD, 8'h22, 8'h00, 4, 1'b0);
    check("hold_wr_pulses", wr_count - w0, 0);
    check("hold_rd_pulses", rd_count - r0, 1);

    // NOP: no memory activity, bus holds last address
    w0 = wr_count;
    r0 = rd_count;
    send_req(OP_NOP, 8'h77, 8'h11, 0, 1'b0);
    check("nop_mem_pulses", (wr_count - w0) + (rd_count - r0), 0);
    check("nop_addr_hold", mem_address, 8'h22);

    // Reset while SWAP is in WRITE_BACK
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SWAP;
    bus.req_addr  = 8'h23;
    bus.req_wdata = 8'h77;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("swap_rst_state", dbg_state, WRITE_BACK);
    w0 = wr_count;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("swap_rst_no_write", wr_count - w0, 0);
    check("swap_rst_state_idle", dbg_state, IDLE);
    check("swap_rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    check("swap_rst_rsp_rdata", bus.rsp_rdata, 0);
    check("swap_rst_mem_en", {30'd0, mem_read, mem_write}, 0);
    check("swap_rst_mem_address", mem_address, 0);
    check("swap_rst_mem_data", mem_write_data, 0);
    check("swap_rst_mem23", mem[8'h23], 8'h03);

    // Store into the protectable region
    w0 = wr_count;
    send_req(OP_STORE, 8'h10, 8'hAA, 0, 1'b0);
    check("prot_wr_pulses", wr_count - w0, PROT ? 0 : 1);
    check("prot_mem10", mem[8'h10], PROT ? (8'h10 ^ 8'h5A) : 8'hAA);

    // Random traffic with random response back-pressure
    for (int i = 0; i < 24; i++) begin
      send_req(2'($urandom_range(0, 3)), 8'h30 + 8'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), 0, 1'b1);
    end
    for (int a = 8'h30; a < 8'h40; a++) check("rand_mem", mem[a], ref_mem[a]);

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
